// File: rtl/segre_pkg.sv
// Shared types for the Segre core: pipeline state, memory operation/size and port phase.
package segre_pkg;

  localparam int unsigned SEGRE_ADDR_SIZE = 32;
  localparam int unsigned SEGRE_WORD_SIZE = 32;

  typedef enum logic [2:0] {
    IF_STATE,
    ID_STATE,
    EX_STATE,
    MEM_STATE,
    WB_STATE
  } fsm_state_e;

  typedef enum logic [1:0] {
    MEMOP_NONE,
    MEMOP_LOAD,
    MEMOP_STORE
  } memop_e;

  typedef enum logic [1:0] {
    MEM_BYTE,
    MEM_HALF,
    MEM_WORD
  } memsize_e;

  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_WAIT_GNT,
    PH_WAIT_RSP
  } mem_phase_e;

  // Natural alignment check on the two low address bits.
  function automatic logic is_misaligned(input memsize_e size, input logic [1:0] lsb);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_HALF: mis = lsb[0];
      MEM_WORD: mis = (lsb != 2'b00);
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/segre_core_ctrl_mem_port.sv
// Single shared memory port: req/gnt/rvalid handshake with one outstanding transaction.
module segre_mem_port
  import segre_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = SEGRE_ADDR_SIZE,
  parameter int unsigned WORD_SIZE = SEGRE_WORD_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 start_i,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  input  memsize_e             size_i,
  output logic                 idle_o,
  output logic                 done_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  output memsize_e             mem_size_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i
);

  mem_phase_e           phase_q, phase_d;
  logic                 load_req;
  logic                 outstanding;
  logic                 we_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  memsize_e             size_q;

  // Phase register; reset abandons any in-flight transaction.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      phase_q <= PH_ISSUE;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase sequencing: gnt only matters while requesting, rvalid only while outstanding.
  always_comb begin
    phase_d  = phase_q;
    load_req = 1'b0;
    case (phase_q)
      PH_ISSUE: begin
        if (start_i) begin
          load_req = 1'b1;
          phase_d  = PH_WAIT_GNT;
        end
      end
      PH_WAIT_GNT: begin
        if (mem_gnt_i) begin
          phase_d = PH_WAIT_RSP;
        end
      end
      PH_WAIT_RSP: begin
        if (mem_rvalid_i) begin
          phase_d = PH_ISSUE;
        end
      end
      default: phase_d = PH_ISSUE;
    endcase
  end

  // Request registers: loaded once at issue and held stable until granted.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= MEM_BYTE;
    end else if (load_req) begin
      we_q    <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      size_q  <= size_i;
    end
  end

  assign outstanding = (phase_q == PH_WAIT_RSP);
  assign idle_o      = (phase_q == PH_ISSUE);
  assign done_o      = outstanding && mem_rvalid_i;
  assign mem_req_o   = (phase_q == PH_WAIT_GNT);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_size_o  = size_q;

endmodule

// File: rtl/segre_core_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer owning the shared memory port.
module segre_core_ctrl
  import segre_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = SEGRE_ADDR_SIZE,
  parameter int unsigned WORD_SIZE = SEGRE_WORD_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  output fsm_state_e           fsm_state_o,
  input  logic [ADDR_SIZE-1:0] if_addr_i,
  output logic [WORD_SIZE-1:0] instr_o,
  input  memop_e               mem_op_i,
  input  logic [ADDR_SIZE-1:0] dm_addr_i,
  input  logic [WORD_SIZE-1:0] dm_wdata_i,
  input  memsize_e             dm_size_i,
  output logic [WORD_SIZE-1:0] dm_rdata_o,
  output logic                 misalign_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  output memsize_e             mem_size_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [WORD_SIZE-1:0] mem_rdata_i,
  output logic [63:0]          instret_o
);

  fsm_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [WORD_SIZE-1:0] dm_rdata_q, dm_rdata_d;
  logic [63:0]          instret_q, instret_d;
  logic                 misalign_q, misalign_d;

  logic                 port_start;
  logic                 port_we;
  logic [ADDR_SIZE-1:0] port_addr;
  logic [WORD_SIZE-1:0] port_wdata;
  memsize_e             port_size;
  logic                 port_idle;
  logic                 port_done;
  logic                 dm_misaligned;

  assign dm_misaligned = is_misaligned(dm_size_i, dm_addr_i[1:0]);

  segre_mem_port #(
    .ADDR_SIZE(ADDR_SIZE),
    .WORD_SIZE(WORD_SIZE)
  ) u_mem_port (
    .clk_i       (clk_i),
    .rsn_i       (rsn_i),
    .start_i     (port_start),
    .we_i        (port_we),
    .addr_i      (port_addr),
    .wdata_i     (port_wdata),
    .size_i      (port_size),
    .idle_o      (port_idle),
    .done_o      (port_done),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_size_o  (mem_size_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i)
  );

  // Sequencer state and architectural registers.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= IF_STATE;
      instr_q    <= '0;
      dm_rdata_q <= '0;
      instret_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      dm_rdata_q <= dm_rdata_d;
      instret_q  <= instret_d;
      misalign_q <= misalign_d;
    end
  end

  // Next state and port requests. Requests are launched on the transition into
  // IF/MEM so mem_req_o is already high in the first cycle of that state; the
  // IF-with-idle-port case only occurs straight out of reset.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    dm_rdata_d = dm_rdata_q;
    instret_d  = instret_q;
    misalign_d = 1'b0;
    port_start = 1'b0;
    port_we    = 1'b0;
    port_addr  = if_addr_i;
    port_wdata = '0;
    port_size  = MEM_WORD;
    case (state_q)
      IF_STATE: begin
        if (port_idle) begin
          port_start = 1'b1;
        end
        if (port_done) begin
          instr_d = mem_rdata_i;
          state_d = ID_STATE;
        end
      end
      ID_STATE: begin
        state_d = EX_STATE;
      end
      EX_STATE: begin
        if (mem_op_i != MEMOP_NONE) begin
          state_d    = MEM_STATE;
          port_addr  = dm_addr_i;
          port_wdata = dm_wdata_i;
          port_size  = dm_size_i;
          port_we    = (mem_op_i == MEMOP_STORE);
          if (dm_misaligned) begin
            misalign_d = 1'b1;
          end else begin
            port_start = 1'b1;
          end
        end else begin
          state_d = WB_STATE;
        end
      end
      MEM_STATE: begin
        if (misalign_q) begin
          state_d = WB_STATE;
        end else if (port_done) begin
          if (!mem_we_o) begin
            dm_rdata_d = mem_rdata_i;
          end
          state_d = WB_STATE;
        end
      end
      WB_STATE: begin
        instret_d  = instret_q + 64'd1;
        port_start = 1'b1;
        state_d    = IF_STATE;
      end
      default: begin
        state_d = IF_STATE;
      end
    endcase
  end

  assign fsm_state_o = state_q;
  assign instr_o     = instr_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign instret_o   = instret_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_segre_core_ctrl.sv
// Directed bench for segre_core_ctrl with a behavioural req/gnt/rvalid memory.
module tb_segre_core_ctrl;
  import segre_pkg::*;

  localparam logic [31:0] FETCH_PC = 32'h0000_0040;
  localparam logic [31:0] IWORD    = 32'h0050_0093;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  fsm_state_e  fsm_state_o;
  logic [31:0] if_addr_i;
  logic [31:0] instr_o;
  memop_e      mem_op_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  memsize_e    dm_size_i;
  logic [31:0] dm_rdata_o;
  logic        misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  memsize_e    mem_size_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [63:0] instret_o;

  always #5 clk_i = ~clk_i;

  segre_core_ctrl #(.ADDR_SIZE(32), .WORD_SIZE(32)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .fsm_state_o(fsm_state_o), .if_addr_i(if_addr_i),
    .instr_o(instr_o), .mem_op_i(mem_op_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_size_i(dm_size_i), .dm_rdata_o(dm_rdata_o), .misalign_o(misalign_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .instret_o(instret_o)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Memory model: fetches are zero-wait, data accesses use the configured delays.
  int unsigned gnt_delay_cfg = 0, rsp_delay_cfg = 0;
  int unsigned gnt_cnt = 0, rsp_cnt = 0, cur_gnt = 0, cur_rsp = 0;
  bit          pending = 1'b0;
  bit          stray = 1'b0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == FETCH_PC) return IWORD;
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  always @(negedge clk_i) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'hBAD0_BAD0;
    if (!rsn_i) begin
      pending = 1'b0;
      gnt_cnt = 0;
    end else begin
      if (stray) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
      end
      if (pending) begin
        if (rsp_cnt >= cur_rsp) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem_word(pend_addr);
          pending      = 1'b0;
        end else begin
          rsp_cnt++;
        end
      end else if (mem_req_o) begin
        cur_gnt = (mem_addr_o == FETCH_PC) ? 0 : gnt_delay_cfg;
        if (gnt_cnt >= cur_gnt) begin
          mem_gnt_i = 1'b1;
          pending   = 1'b1;
          rsp_cnt   = 0;
          gnt_cnt   = 0;
          cur_rsp   = (mem_addr_o == FETCH_PC) ? 0 : rsp_delay_cfg;
          pend_addr = mem_addr_o;
        end else begin
          gnt_cnt++;
        end
      end
    end
  end

  typedef struct {
    memop_e      op;
    logic [31:0] addr;
    logic [31:0] wdata;
    memsize_e    size;
    int unsigned gd;
    int unsigned rd;
    int unsigned cyc;
    int unsigned mis;
    int unsigned reqc;
    logic [31:0] dm;
  } vec_t;

  vec_t vecs[8];

  // Runs one instruction starting at the first IF cycle; returns at the next first IF cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int unsigned cyc, mis, reqc;
    bit          done, stable;
    logic [63:0] inst0;
    logic [31:0] a0, w0;
    logic        we0;
    memsize_e    s0;
    mem_op_i      = v.op;
    dm_addr_i     = v.addr;
    dm_wdata_i    = v.wdata;
    dm_size_i     = v.size;
    gnt_delay_cfg = v.gd;
    rsp_delay_cfg = v.rd;
    inst0 = instret_o;
    cyc = 0; mis = 0; reqc = 0; done = 1'b0; stable = 1'b1;
    a0 = '0; w0 = '0; we0 = 1'b0; s0 = MEM_BYTE;
    while (!done && cyc < 64) begin
      cyc++;
      if (misalign_o) mis++;
      if (fsm_state_o == MEM_STATE && mem_req_o) begin
        if (reqc == 0) begin
          a0 = mem_addr_o; w0 = mem_wdata_o; we0 = mem_we_o; s0 = mem_size_o;
        end else if (mem_addr_o != a0 || mem_wdata_o != w0 || mem_we_o != we0 || mem_size_o != s0) begin
          stable = 1'b0;
        end
        reqc++;
      end
      if (fsm_state_o == WB_STATE) done = 1'b1;
      else @(negedge clk_i);
    end
    chk($sformatf("v%0d reached WB", idx), 64'(done), 64'd1);
    chk($sformatf("v%0d cycles", idx), 64'(cyc), 64'(v.cyc));
    chk($sformatf("v%0d misalign pulses", idx), 64'(mis), 64'(v.mis));
    chk($sformatf("v%0d MEM req cycles", idx), 64'(reqc), 64'(v.reqc));
    if (reqc > 0) begin
      chk($sformatf("v%0d req addr", idx), 64'(a0), 64'(v.addr));
      chk($sformatf("v%0d req we", idx), 64'(we0), 64'(v.op == MEMOP_STORE));
      chk($sformatf("v%0d req size", idx), 64'(s0), 64'(v.size));
      chk($sformatf("v%0d req stable", idx), 64'(stable), 64'd1);
      if (v.op == MEMOP_STORE) chk($sformatf("v%0d req wdata", idx), 64'(w0), 64'(v.wdata));
    end
    @(negedge clk_i);
    chk($sformatf("v%0d back to IF", idx), 64'(fsm_state_o), 64'(IF_STATE));
    chk($sformatf("v%0d dm_rdata", idx), 64'(dm_rdata_o), 64'(v.dm));
    chk($sformatf("v%0d instret", idx), instret_o, inst0 + 64'd1);
  endtask

  fsm_state_e trace[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{MEMOP_NONE,  32'h0000_0000, 32'h0000_0000, MEM_WORD, 0, 0, 5,  0, 0, 32'h0000_0000};
    vecs[1] = '{MEMOP_LOAD,  32'h0000_0100, 32'h0000_0000, MEM_WORD, 0, 0, 7,  0, 1, 32'hDEAD_BEEF};
    vecs[2] = '{MEMOP_STORE, 32'h0000_0200, 32'hCAFE_F00D, MEM_WORD, 3, 0, 10, 0, 4, 32'hDEAD_BEEF};
    vecs[3] = '{MEMOP_STORE, 32'h0000_0101, 32'h0000_1111, MEM_HALF, 0, 0, 6,  1, 0, 32'hDEAD_BEEF};
    vecs[4] = '{MEMOP_LOAD,  32'h0000_0102, 32'h0000_0000, MEM_HALF, 0, 2, 9,  0, 1, 32'hFEFD_0102};
    vecs[5] = '{MEMOP_LOAD,  32'h0000_0102, 32'h0000_0000, MEM_WORD, 0, 0, 6,  1, 0, 32'hFEFD_0102};
    vecs[6] = '{MEMOP_LOAD,  32'h0000_0103, 32'h0000_0000, MEM_BYTE, 1, 1, 9,  0, 2, 32'hFEFC_0103};
    vecs[7] = '{MEMOP_STORE, 32'h0000_00FE, 32'hA5A5_5A5A, MEM_HALF, 0, 0, 7,  0, 1, 32'hFEFC_0103};
    trace = '{IF_STATE, IF_STATE, ID_STATE, EX_STATE, WB_STATE, IF_STATE};

    rsn_i      = 1'b0;
    if_addr_i  = FETCH_PC;
    mem_op_i   = MEMOP_NONE;
    dm_addr_i  = '0;
    dm_wdata_i = '0;
    dm_size_i  = MEM_WORD;

    // Reset values.
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset state", 64'(fsm_state_o), 64'(IF_STATE));
    chk("reset req", 64'(mem_req_o), 64'd0);
    chk("reset instr", 64'(instr_o), 64'd0);
    chk("reset dm_rdata", 64'(dm_rdata_o), 64'd0);
    chk("reset instret", instret_o, 64'd0);
    chk("reset misalign", 64'(misalign_o), 64'd0);
    chk("reset req regs", {mem_addr_o, mem_wdata_o}, 64'd0);
    chk("reset we/size", {61'd0, mem_we_o, mem_size_o}, 64'd0);

    // First instruction out of reset, zero-wait ALU op.
    @(posedge clk_i);
    #1 rsn_i = 1'b1;
    @(negedge clk_i);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      chk($sformatf("boot trace %0d", k), 64'(fsm_state_o), 64'(trace[k]));
      if (k == 2) chk("boot instr", 64'(instr_o), 64'(IWORD));
    end
    chk("boot instret", instret_o, 64'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset while a load is outstanding, then a stray rvalid after release.
    mem_op_i      = MEMOP_LOAD;
    dm_addr_i     = 32'h0000_0100;
    dm_size_i     = MEM_WORD;
    gnt_delay_cfg = 0;
    rsp_delay_cfg = 5;
    for (int i = 0; i < 20 && fsm_state_o != MEM_STATE; i++) @(negedge clk_i);
    chk("midrst reached MEM", 64'(fsm_state_o), 64'(MEM_STATE));
    @(negedge clk_i);
    chk("midrst in WAIT_RSP", 64'(mem_req_o), 64'd0);
    rsn_i = 1'b0;
    #1;
    chk("midrst state", 64'(fsm_state_o), 64'(IF_STATE));
    chk("midrst instr", 64'(instr_o), 64'd0);
    chk("midrst dm_rdata", 64'(dm_rdata_o), 64'd0);
    chk("midrst instret", instret_o, 64'd0);
    mem_op_i = MEMOP_NONE;
    repeat (2) @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
    stray = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i);
    #1 stray = 1'b0;
    chk("stray no capture", 64'(instr_o), 64'd0);
    chk("stray state", 64'(fsm_state_o), 64'(IF_STATE));
    chk("refetch req", 64'(mem_req_o), 64'd1);
    chk("refetch addr", 64'(mem_addr_o), 64'(FETCH_PC));
    chk("refetch we", 64'(mem_we_o), 64'd0);
    for (int i = 0; i < 20 && fsm_state_o != WB_STATE; i++) @(negedge clk_i);
    chk("refetch reached WB", 64'(fsm_state_o), 64'(WB_STATE));
    chk("refetch instr", 64'(instr_o), 64'(IWORD));
    @(negedge clk_i);
    chk("refetch back to IF", 64'(fsm_state_o), 64'(IF_STATE));
    chk("refetch instret", instret_o, 64'd1);

    // instret wrap-around.
    @(negedge clk_i);
    @(negedge clk_i);
    chk("wrap in ID", 64'(fsm_state_o), 64'(ID_STATE));
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk_i);
    release dut.instret_q;
    chk("wrap preset", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk_i);
    chk("wrap in WB", 64'(fsm_state_o), 64'(WB_STATE));
    @(negedge clk_i);
    chk("wrap instret", instret_o, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/segre_core_ctrl.md
Name: segre_core_ctrl

Overview:
Multi-cycle sequencer for the Segre core. Generates the global fsm_state (IF/ID/EX/MEM/WB) consumed by every stage. Owns the single shared memory port and hands it to instruction fetch in IF_STATE and to the data access in MEM_STATE. Stalls the sequence on a variable-latency req/gnt/rvalid memory handshake, and maintains a retired-instruction counter.

Parameters:
ADDR_SIZE, 32, address width (matches segre_pkg)
WORD_SIZE, 32, data width (matches segre_pkg)

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rsn_i  in  1  reset, asynchronous, active-low
fsm_state_o  out  fsm_state_e  current core state
if_addr_i  in  ADDR_SIZE  fetch PC from the IF stage
instr_o  out  WORD_SIZE  last fetched instruction (registered)
mem_op_i  in  memop_e  from decode: MEMOP_NONE/LOAD/STORE; sampled in the last EX cycle
dm_addr_i  in  ADDR_SIZE  data address; sampled in the last EX cycle
dm_wdata_i  in  WORD_SIZE  store data; sampled in the last EX cycle
dm_size_i  in  memsize_e  BYTE/HALF/WORD; sampled in the last EX cycle
dm_rdata_o  out  WORD_SIZE  last load data (registered)
misalign_o  out  1  one-cycle pulse: data access rejected as misaligned
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = write
mem_addr_o  out  ADDR_SIZE  request address
mem_wdata_o  out  WORD_SIZE  write data
mem_size_o  out  memsize_e  access size
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  response (read data or write ack)
mem_rdata_i  in  WORD_SIZE  read data, valid with mem_rvalid_i
instret_o  out  64  retired instruction count

Behaviour:
- Reset (asynchronous, active-low):
  - fsm_state_o=IF_STATE, port phase=ISSUE, mem_req_o=0.
  - instr_o=0, dm_rdata_o=0, instret_o=0, misalign_o=0.
  - Request registers (mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o) cleared to 0.
- Port phase FSM (internal): ISSUE -> WAIT_GNT -> WAIT_RSP -> ISSUE.
  - ISSUE: on entry to IF_STATE or MEM_STATE, register the address, data, size and we, and assert mem_req_o.
  - WAIT_GNT: mem_req_o stays high, with address/data/size/we stable, until the cycle mem_gnt_i=1. The request cycle and the gnt cycle may coincide.
  - WAIT_RSP: mem_req_o=0. At most one outstanding transaction. mem_rvalid_i arrives at least 1 cycle after gnt.
- Core sequence:
  - IF_STATE: fetch if_addr_i, WORD size, read. On the rvalid cycle, instr_o<=mem_rdata_i, and the next state is ID_STATE.
  - ID_STATE: 1 cycle, then EX_STATE.
  - EX_STATE: 1 cycle. mem_op_i!=NONE -> MEM_STATE (operands captured); NONE -> WB_STATE.
  - MEM_STATE: issue a load or store.
    - Load rvalid: dm_rdata_o<=mem_rdata_i, then WB_STATE.
    - Store rvalid (ack): WB_STATE, dm_rdata_o unchanged.
  - WB_STATE: 1 cycle. instret_o+=1, then IF_STATE.
- Latency with zero-wait memory (gnt in the request cycle, rvalid the next cycle):
  - ALU instruction: 5 cycles.
  - Load/store: 7 cycles.
  - Each gnt delay cycle or rvalid delay cycle adds 1.
- Misalignment:
  - HALF with addr[0]=1, or WORD with addr[1:0]!=0: no memory request is issued.
  - misalign_o=1 for the single MEM_STATE cycle; next state is WB_STATE; dm_rdata_o unchanged.
- Fetches are always WORD size. Fetch alignment is the IF stage's responsibility.
- mem_rvalid_i with no outstanding transaction (e.g. after a mid-transaction reset): ignored. No state change, no capture.
- mem_gnt_i while mem_req_o=0: ignored.
- instret_o wraps modulo 2^64.
- Reset asserted mid-WAIT_GNT/WAIT_RSP: the outstanding transaction is abandoned and mem_req_o drops asynchronously.

Decomposition:
- segre_pkg gains:
  - memop_e {MEMOP_NONE, MEMOP_LOAD, MEMOP_STORE}
  - memsize_e {MEM_BYTE, MEM_HALF, MEM_WORD}
  - mem_phase_e {PH_ISSUE, PH_WAIT_GNT, PH_WAIT_RSP}
- fsm_state_e is already in segre_pkg.
- Sub-module segre_mem_port: port phase FSM, request registers and outstanding flag. Exposes start/is_write/done handshake to the sequencer.

Test Plan:
- Reset, zero-wait memory, mem_op_i=NONE -> states IF,IF,ID,EX,WB,IF; instr_o=mem_rdata_i (0x00500093); instret_o=1 after 5 cycles.
- Load, dm_addr_i=0x100, WORD, zero-wait -> 7-cycle instruction; MEM request with mem_we_o=0 and addr 0x100; dm_rdata_o=0xDEADBEEF.
- Store with gnt delayed 3 cycles -> mem_req_o high with addr/wdata stable for 4 cycles; WB entered the cycle after rvalid; instruction takes 10 cycles.
- HALF store at 0x101 -> misalign_o pulse for 1 cycle, no mem_req_o in MEM, next state WB, instret_o still increments.
- rsn_i low while in WAIT_RSP, then a stray rvalid after reset release -> fsm_state_o=IF_STATE, instr_o=0; stray rvalid ignored; fresh fetch issued.
- instret_o preset to 0xFFFF_FFFF_FFFF_FFFF via force, one instruction retires -> instret_o=0.
